// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-channel valid/ready arbiter feeding one registered output beat.
// Policy macro RR_ARB_MUX_FIXED_PRIO_EN: defined = lowest index wins, else round-robin.
module rr_arb_mux #(
  parameter int N = 4,
  parameter int W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           in_valid,
  input  logic [N*W-1:0]         in_data,
  output logic [N-1:0]           in_ready,
  output logic                   out_valid,
  output logic [W-1:0]           out_data,
  output logic [$clog2(N)-1:0]   out_chan,
  input  logic                   out_ready
);

  localparam int CW = $clog2(N);

  logic          out_valid_q;
  logic          out_valid_d;
  logic [W-1:0]  out_data_q;
  logic [W-1:0]  out_data_d;
  logic [CW-1:0] out_chan_q;
  logic [CW-1:0] out_chan_d;

  logic          ld;
  logic          any_valid;
  logic [CW-1:0] g;
  logic          found;
  logic          xfer_in;

  assign ld        = !out_valid_q || out_ready;
  assign any_valid = |in_valid;
  assign xfer_in   = !rst && ld && any_valid;

`ifdef RR_ARB_MUX_FIXED_PRIO_EN

  // Fixed priority: lowest asserted index wins.
  always_comb begin
    g     = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && in_valid[k]) begin
        found = 1'b1;
        g     = CW'(k);
      end
    end
  end

`else

  logic [CW-1:0] ptr_q;
  logic [CW-1:0] ptr_d;

  // Round-robin: first requester at or after ptr, wrapping modulo N.
  always_comb begin
    g     = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && in_valid[(int'(ptr_q) + k) % N]) begin
        found = 1'b1;
        g     = CW'((int'(ptr_q) + k) % N);
      end
    end
  end

  // Pointer moves just past the winner, only on an accepted beat.
  always_comb begin
    ptr_d = ptr_q;
    if (xfer_in) begin
      ptr_d = (g == CW'(N - 1)) ? '0 : g + CW'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

`endif

  // One-hot ready for the winner, gated by load enable and reset.
  always_comb begin
    in_ready = '0;
    if (xfer_in) begin
      in_ready[g] = 1'b1;
    end
  end

  // Next output beat: load winner, drain when idle, hold under backpressure.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    if (ld) begin
      out_valid_d = any_valid;
      if (any_valid) begin
        out_data_d = in_data[int'(g)*W +: W];
        out_chan_d = g;
      end
    end
  end

  // Output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// tb_rr_arb_mux: directed vector table plus randomized run against a model.
// Follows RR_ARB_MUX_FIXED_PRIO_EN to pick the expected arbitration policy.
module tb_rr_arb_mux;

  localparam int N  = 4;
  localparam int W  = 4;
  localparam int CW = $clog2(N);

  logic             clk;
  logic             rst;
  logic [N-1:0]     in_valid;
  logic [N*W-1:0]   in_data;
  logic [N-1:0]     in_ready;
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic [CW-1:0]    out_chan;
  logic             out_ready;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic           rst;
    logic [N-1:0]   iv;
    logic [N*W-1:0] id;
    logic           ordy;
    logic [N-1:0]   rdy;
    logic           ov;
    logic [W-1:0]   od;
    logic [CW-1:0]  oc;
  } vec_t;

  vec_t tab[$];

  // Reference state: one held beat plus the fairness pointer.
  bit           m_ov;
  bit [W-1:0]   m_od;
  int           m_oc;
  int           m_ptr;

  rr_arb_mux #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int grant(input logic [N-1:0] iv, input int p);
    int start;
`ifdef RR_ARB_MUX_FIXED_PRIO_EN
    start = 0;
`else
    start = p;
`endif
    for (int k = 0; k < N; k++) begin
      if (iv[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [N-1:0] iv,
                      input logic [N*W-1:0] id, input logic ordy,
                      input bit use_tab, input vec_t v);
    bit ld;
    int g;
    logic [N-1:0] er;
    bit dchk;
    rst       = r;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    #1;
    ld = !m_ov || ordy;
    g  = grant(iv, m_ptr);
    er = '0;
    if (!r && ld && g >= 0) er[g] = 1'b1;
    chk("in_ready", 32'(in_ready), use_tab ? 32'(v.rdy) : 32'(er));
    chk("onehot", 32'($onehot0(in_ready)), 32'd1);
    @(posedge clk);
    #1;
    if (r) begin
      m_ov = 0; m_od = '0; m_oc = 0; m_ptr = 0;
    end else if (ld) begin
      if (g >= 0) begin
        m_ov  = 1;
        m_od  = id[g*W +: W];
        m_oc  = g;
        m_ptr = (g + 1) % N;
      end else begin
        m_ov = 0;
      end
    end
    if (use_tab) begin
      chk("out_valid", 32'(out_valid), 32'(v.ov));
      dchk = v.ov || r;
      if (dchk) begin
        chk("out_data", 32'(out_data), 32'(v.od));
        chk("out_chan", 32'(out_chan), 32'(v.oc));
      end
    end else begin
      chk("out_valid", 32'(out_valid), 32'(m_ov));
      if (m_ov || r) begin
        chk("out_data", 32'(out_data), 32'(m_od));
        chk("out_chan", 32'(out_chan), 32'(m_oc));
      end
    end
  endtask

  vec_t dummy;

  initial begin
    rst = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b1;
    m_ov = 0; m_od = '0; m_oc = 0; m_ptr = 0;
    dummy = '{1'b0, '0, '0, 1'b0, '0, 1'b0, '0, '0};
    @(posedge clk);
    #1;

    // rst, iv, id, ordy -> rdy, ov, od, oc
`ifdef RR_ARB_MUX_FIXED_PRIO_EN
    tab.push_back('{1'b1, 4'b1111, 16'hDCBA, 1'b1, 4'b0000, 1'b0, 4'h0, 2'd0});
    tab.push_back('{1'b0, 4'b0100, 16'h0C00, 1'b1, 4'b0100, 1'b1, 4'hC, 2'd2});
    tab.push_back('{1'b0, 4'b1111, 16'hDCBA, 1'b1, 4'b0001, 1'b1, 4'hA, 2'd0});
    tab.push_back('{1'b0, 4'b1111, 16'hDCBA, 1'b1, 4'b0001, 1'b1, 4'hA, 2'd0});
    tab.push_back('{1'b0, 4'b1111, 16'hDCBA, 1'b1, 4'b0001, 1'b1, 4'hA, 2'd0});
    tab.push_back('{1'b0, 4'b1100, 16'hDCBA, 1'b0, 4'b0000, 1'b1, 4'hA, 2'd0});
    tab.push_back('{1'b0, 4'b1100, 16'hDCBA, 1'b1, 4'b0100, 1'b1, 4'hC, 2'd2});
    tab.push_back('{1'b0, 4'b0000, 16'hDCBA, 1'b1, 4'b0000, 1'b0, 4'hC, 2'd2});
    tab.push_back('{1'b1, 4'b1111, 16'hDCBA, 1'b1, 4'b0000, 1'b0, 4'h0, 2'd0});
`else
    tab.push_back('{1'b1, 4'b1111, 16'hDCBA, 1'b1, 4'b0000, 1'b0, 4'h0, 2'd0});
    tab.push_back('{1'b0, 4'b0100, 16'h0C00, 1'b1, 4'b0100, 1'b1, 4'hC, 2'd2});
    tab.push_back('{1'b0, 4'b0000, 16'h0C00, 1'b1, 4'b0000, 1'b0, 4'hC, 2'd2});
    tab.push_back('{1'b1, 4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 4'h0, 2'd0});
    tab.push_back('{1'b0, 4'b1111, 16'hDCBA, 1'b1, 4'b0001, 1'b1, 4'hA, 2'd0});
    tab.push_back('{1'b0, 4'b1111, 16'hDCBA, 1'b1, 4'b0010, 1'b1, 4'hB, 2'd1});
    tab.push_back('{1'b0, 4'b1111, 16'hDCBA, 1'b1, 4'b0100, 1'b1, 4'hC, 2'd2});
    tab.push_back('{1'b0, 4'b1111, 16'hDCBA, 1'b1, 4'b1000, 1'b1, 4'hD, 2'd3});
    tab.push_back('{1'b0, 4'b1111, 16'hDCBA, 1'b1, 4'b0001, 1'b1, 4'hA, 2'd0});
    tab.push_back('{1'b0, 4'b0001, 16'h0057, 1'b1, 4'b0001, 1'b1, 4'h7, 2'd0});
    tab.push_back('{1'b0, 4'b0011, 16'h0057, 1'b0, 4'b0000, 1'b1, 4'h7, 2'd0});
    tab.push_back('{1'b0, 4'b0011, 16'h0057, 1'b0, 4'b0000, 1'b1, 4'h7, 2'd0});
    tab.push_back('{1'b0, 4'b0011, 16'h0057, 1'b0, 4'b0000, 1'b1, 4'h7, 2'd0});
    tab.push_back('{1'b0, 4'b0011, 16'h0057, 1'b1, 4'b0010, 1'b1, 4'h5, 2'd1});
    tab.push_back('{1'b0, 4'b0100, 16'h0300, 1'b1, 4'b0100, 1'b1, 4'h3, 2'd2});
    tab.push_back('{1'b0, 4'b1001, 16'h9001, 1'b1, 4'b1000, 1'b1, 4'h9, 2'd3});
    tab.push_back('{1'b0, 4'b1001, 16'h9001, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd0});
    tab.push_back('{1'b0, 4'b1001, 16'h9001, 1'b1, 4'b1000, 1'b1, 4'h9, 2'd3});
    tab.push_back('{1'b1, 4'b1111, 16'hDCBA, 1'b1, 4'b0000, 1'b0, 4'h0, 2'd0});
    tab.push_back('{1'b0, 4'b1111, 16'hDCBA, 1'b1, 4'b0001, 1'b1, 4'hA, 2'd0});
    tab.push_back('{1'b0, 4'b0010, 16'h00E0, 1'b0, 4'b0000, 1'b1, 4'hA, 2'd0});
    tab.push_back('{1'b0, 4'b0010, 16'h00E0, 1'b1, 4'b0010, 1'b1, 4'hE, 2'd1});
`endif

    foreach (tab[i]) begin
      step(tab[i].rst, tab[i].iv, tab[i].id, tab[i].ordy, 1'b1, tab[i]);
    end

    // Randomized traffic, occasional reset, ~70% downstream ready.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), N'($urandom),
           (N*W)'($urandom), ($urandom_range(0, 9) < 7), 1'b0, dummy);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arb_mux.md
RR_ARB_MUX -- requirements
Module: rr_arb_mux

Interface
REQ-001 Parameter N, default 4: number of input channels; legal range 2..16.
REQ-002 Parameter W, default 4: data width per channel; legal range 1..64.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 Port in_valid, input, N: bit i set means channel i offers data.
REQ-006 Port in_data, input, N*W: channel i occupies bits [i*W +: W].
REQ-007 Port in_ready, output, N: bit i set means channel i is accepted this cycle.
REQ-008 Port out_valid, output, 1: the output register holds a beat.
REQ-009 Port out_data, output, W: the registered data beat.
REQ-010 Port out_chan, output, $clog2(N): source channel index of the held beat.
REQ-011 Port out_ready, input, 1: the downstream consumer accepts the beat.

Function
REQ-012 A transfer on the input side occurs on channel i when in_valid[i] and in_ready[i] are both high at a rising edge.
REQ-013 A transfer on the output side occurs when out_valid and out_ready are both high at a rising edge.
REQ-014 The load enable, ld, is (!out_valid || out_ready); it is combinational.
REQ-015 At most one in_ready bit is high in any cycle.
REQ-016 in_ready[g] is high only when ld is high, some in_valid bit is set, and g is the granted index; in_ready is purely combinational from in_valid, ptr and ld.
REQ-017 Grant (round-robin): g is the first index with in_valid set, scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (modulo N).
REQ-018 ptr is an internal $clog2(N)-bit register; after an input transfer, ptr becomes (g+1) mod N, wrapping from N-1 to 0.
REQ-019 ptr is unchanged in any cycle with no input transfer.
REQ-020 On an input transfer, out_data <= in_data[g], out_chan <= g, out_valid <= 1, at the next edge; latency is exactly 1 cycle.
REQ-021 When ld is high and no in_valid bit is set, the next-cycle out_valid is 0 (an output transfer drains the register).
REQ-022 When out_valid is high and out_ready is low, out_valid, out_data and out_chan hold stable and all in_ready bits are low.
REQ-023 Simultaneous output and input transfer in one cycle: the register is replaced with no bubble, giving full throughput of one beat per cycle.
REQ-024 in_data of non-granted channels has no effect; X on those lanes does not propagate to outputs.
REQ-025 in_valid is not required to be held by the source; deasserting it before acceptance is legal and simply removes the request.

Reset
REQ-026 While rst is high at an edge: out_valid=0, out_data=0, out_chan=0, ptr=0.
REQ-027 While rst is high, in_ready is all zeros regardless of the other inputs.
REQ-028 Reset mid-transfer discards the held beat; no input transfer is counted in the reset cycle.

Configuration
REQ-029 Macro RR_ARB_MUX_FIXED_PRIO_EN selects the arbitration policy.
REQ-030 With RR_ARB_MUX_FIXED_PRIO_EN defined, g is the lowest index with in_valid set, ptr is not implemented, and REQ-017 to REQ-019 do not apply.
REQ-031 With RR_ARB_MUX_FIXED_PRIO_EN undefined (the default), round-robin per REQ-017 to REQ-019 applies.
REQ-032 The macro does not change the interface, the latency or the reset behaviour.

Verification
REQ-033 Single channel: N=4, W=4, out_ready=1, in_valid=0100, in_data lane2=0xC -> next cycle out_valid=1, out_data=0xC, out_chan=2; in_ready was 0100.
REQ-034 Round-robin fairness: in_valid=1111 held, lanes {0xD,0xC,0xB,0xA} for lanes 3..0, out_ready=1 -> out_chan sequence 0,1,2,3,0 with out_data A,B,C,D,A, and out_valid stays high (no bubbles).
REQ-035 Backpressure: beat 0x7 held with out_ready=0 for 3 cycles while in_valid=0011 -> out_data stays 0x7, in_ready=0000; on out_ready=1, next beat is loaded the same cycle.
REQ-036 Wrap and skip: ptr=3, in_valid=1001 -> grant 3, then grant 0, with ptr wrapping to 0 and then 1.
REQ-037 Reset mid-operation: rst=1 for one cycle while out_valid=1 -> out_valid=0, out_chan=0; the next grant with in_valid=1111 is channel 0.
REQ-038 FIXED_PRIO build: in_valid=1111 held, out_ready=1 -> out_chan is 0 every cycle; in_ready=0001.
